spi_wb_cmd_bridge: RTL

- Protocol engine between the SPI byte-level slave (bit-serial shifter) and the Wishbone fabric (LED, motor, neopixel and UART registers).
- Decodes host frames (read 0xA1 / write 0xA2, 32-bit address MSB-first, 32-bit data LSB-first) and runs one Wishbone classic cycle per frame.
- For reads, supplies the response bytes (header, then data LSB-first) to the SPI slave's transmit side.

---
 rtl/spi_wb_cmd_bridge.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_wb_cmd_bridge.sv
// SPI command frame decoder driving one Wishbone classic cycle per frame.
// Read frames return a header byte plus four data bytes on the SPI transmit side.
module spi_wb_cmd_bridge #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  PAD_BYTE       = 8'h00,
  parameter logic [7:0]  CMD_READ       = 8'hA1,
  parameter logic [7:0]  CMD_WRITE      = 8'hA2,
  parameter logic [7:0]  RSP_OK         = 8'hA3,
  parameter logic [7:0]  RSP_ERR        = 8'hA4
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_cs_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_tx_req,
  output logic [7:0]  o_tx_data,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_busy
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WB, RESP, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q;
  logic          rd_q;
  logic          cs_hi_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [39:0]   rsp_q;
  logic [TW-1:0] tmr_q;

  logic wb_done;
  logic last_byte;
  logic frame_end;

  assign wb_done   = i_wb_ack | i_wb_err | (tmr_q == TMR_LAST);
  assign last_byte = i_rx_valid && (cnt_q == 3'd3);
  // Chip-select release aborts everything except a running bus cycle.
  assign frame_end = i_cs_n && (state_q != WB);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid)
          state_d = (i_rx_data == CMD_READ || i_rx_data == CMD_WRITE) ? ADDR : DRAIN;
      end
      ADDR: begin
        if (last_byte) state_d = rd_q ? WB : WDATA;
      end
      WDATA: begin
        if (last_byte) state_d = WB;
      end
      WB: begin
        if (wb_done) begin
          if (cs_hi_q || i_cs_n) state_d = IDLE;
          else                   state_d = rd_q ? RESP : DRAIN;
        end
      end
      RESP: begin
        if (i_tx_req && cnt_q == 3'd4) state_d = DRAIN;
      end
      DRAIN:   state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (frame_end) state_d = IDLE;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      cs_hi_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rsp_q   <= '0;
      tmr_q   <= '0;
    end else if (frame_end) begin
      cnt_q   <= '0;
      cs_hi_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (i_rx_valid) rd_q <= (i_rx_data == CMD_READ);
        end
        ADDR: begin
          if (i_rx_valid) begin
            adr_q <= {adr_q[23:0], i_rx_data};
            cnt_q <= last_byte ? 3'd0 : cnt_q + 3'd1;
          end
        end
        WDATA: begin
          if (i_rx_valid) begin
            dat_q[{cnt_q[1:0], 3'b000} +: 8] <= i_rx_data;
            cnt_q <= last_byte ? 3'd0 : cnt_q + 3'd1;
          end
        end
        WB: begin
          tmr_q <= tmr_q + TW'(1);
          if (i_cs_n) cs_hi_q <= 1'b1;
          if (wb_done) begin
            tmr_q   <= '0;
            cs_hi_q <= 1'b0;
            cnt_q   <= '0;
            // err takes priority over a simultaneous ack
            if (i_wb_ack && !i_wb_err) rsp_q <= {i_wb_dat, RSP_OK};
            else                       rsp_q <= {32'h0, RSP_ERR};
          end
        end
        RESP: begin
          if (i_tx_req) begin
            rsp_q <= {PAD_BYTE, rsp_q[39:8]};
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data = (state_q == RESP) ? rsp_q[7:0] : PAD_BYTE;
  assign o_wb_cyc  = (state_q == WB);
  assign o_wb_stb  = (state_q == WB);
  assign o_wb_we   = (state_q == WB) && !rd_q;
  assign o_wb_sel  = (state_q == WB) ? 4'hF : 4'h0;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_busy    = (state_q != IDLE);

endmodule
